mcoc_boot_pf: RTL and testbench

Parametrised boot-ROM fetch controller: the next-generation boot ROM front-end for the MCOC cores. It decodes fetch requests (byte/half/word) against an external synchronous ROM macro with configurable read latency, and adds a busy handshake plus a small hit buffer. Optionally it adds a sequential next-word prefetch. It sits between the core fetch port and the boot ROM macro.

---
 rtl/mcoc_boot_pkg.sv | 28 ++
 rtl/mcoc_boot_pf_if.sv | 23 ++
 rtl/mcoc_boot_lane.sv | 21 ++
 rtl/mcoc_boot_pf.sv | 201 ++++++++++++++++++++
 tb/tb_mcoc_boot_pf.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mcoc_boot_pkg.sv
// Shared encodings for the MCOC boot-ROM fetch controller.
// MCOC_BOOT_PF_EN adds the prefetch state to the FSM enum.
package mcoc_boot_pkg;

   localparam logic [1:0] CMD_IDLE = 2'b00;
   localparam logic [1:0] CMD_HALF = 2'b01;
   localparam logic [1:0] CMD_WORD = 2'b10;
   localparam logic [1:0] CMD_BYTE = 2'b11;

   localparam int RLAT_MIN = 1;
   localparam int RLAT_MAX = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
`ifdef MCOC_BOOT_PF_EN
      ST_WAIT,
      ST_PF
`else
      ST_WAIT
`endif
   } st_t;

   function automatic bit rlat_ok(input int r);
      return (r >= RLAT_MIN) && (r <= RLAT_MAX);
   endfunction

endpackage

// File: rtl/mcoc_boot_pf_if.sv
// Fetch port plus ROM macro port of the boot-ROM controller.
// master = core fetch side together with the ROM macro.
interface mcoc_boot_pf_if #(
   parameter int ROM_AW = 7
);
   logic [1:0]        fcmd;
   logic [15:0]       fadr;
   logic              fbsy;
   logic [31:0]       fdat;
   logic              rom_re;
   logic [ROM_AW-1:0] rom_adr;
   logic [31:0]       rom_dat;

   modport master (
      output fcmd, fadr, rom_dat,
      input  fbsy, fdat, rom_re, rom_adr
   );

   modport slave (
      input  fcmd, fadr, rom_dat,
      output fbsy, fdat, rom_re, rom_adr
   );
endinterface

// File: rtl/mcoc_boot_lane.sv
// Big-endian lane extract with zero extension.
// Offset 0 selects the most significant lane.
module mcoc_boot_lane
   import mcoc_boot_pkg::*;
(
   input  logic [1:0]  cmd,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   output logic [31:0] dat
);

   always_comb begin
      dat = word;
      unique case (cmd)
         CMD_HALF: dat = (word >> {~off[1], 4'b0000}) & 32'h0000_ffff;
         CMD_BYTE: dat = (word >> {~off, 3'b000}) & 32'h0000_00ff;
         default:  dat = word;
      endcase
   end

endmodule

// File: rtl/mcoc_boot_pf.sv
// Boot-ROM fetch controller: hit buffer, busy handshake, ROM sequencing.
// MCOC_BOOT_PF_EN adds a next-word prefetch entry.
module mcoc_boot_pf
   import mcoc_boot_pkg::*;
#(
   parameter int ROM_AW = 7,
   parameter int RLAT   = 1
) (
   input logic           clk,
   input logic           rst_n,
   mcoc_boot_pf_if.slave bus
);

   if (!rlat_ok(RLAT)) begin : g_rlat_bad
      $error("mcoc_boot_pf: RLAT out of range");
   end

   typedef logic [ROM_AW-1:0] wadr_t;

   st_t         st;
   logic [2:0]  cnt;
   logic        fbsy;
   logic        rom_re;
   logic [31:0] fdat;
   wadr_t       rom_adr;
   logic        cur_vld;
   wadr_t       cur_adr;
   logic [31:0] cur_dat;
   logic [1:0]  p_cmd;
   logic [1:0]  p_off;
   wadr_t       p_adr;

   wadr_t       r_adr;
   logic [1:0]  r_off;
   logic        acc;
   logic        hit_cur;
   logic [1:0]  l_cmd;
   logic [1:0]  l_off;
   logic [31:0] l_word;
   logic [31:0] lane_dat;
   logic        unused_fadr;

   assign r_adr       = bus.fadr[ROM_AW+1:2];
   assign r_off       = bus.fadr[1:0];
   assign unused_fadr = ^bus.fadr[15:ROM_AW+2];
   assign acc         = (bus.fcmd != CMD_IDLE) && !fbsy;
   assign hit_cur     = cur_vld && (r_adr == cur_adr);

`ifdef MCOC_BOOT_PF_EN
   logic        nxt_vld;
   wadr_t       nxt_adr;
   logic [31:0] nxt_dat;
   logic        hit_nxt;
   logic        pf_req;
   wadr_t       pf_adr;

   assign hit_nxt = nxt_vld && (r_adr == nxt_adr);
   assign pf_req  = fbsy || (acc && !hit_cur);
   assign pf_adr  = fbsy ? p_adr : r_adr;
`endif

   // A pending request always takes its lane from the ROM word landing now
   always_comb begin
      l_cmd  = fbsy ? p_cmd : bus.fcmd;
      l_off  = fbsy ? p_off : r_off;
      l_word = bus.rom_dat;
      if (!fbsy && hit_cur) begin
         l_word = cur_dat;
`ifdef MCOC_BOOT_PF_EN
      end else if (!fbsy && hit_nxt) begin
         l_word = nxt_dat;
`endif
      end
   end

   mcoc_boot_lane u_lane (
      .cmd  (l_cmd),
      .off  (l_off),
      .word (l_word),
      .dat  (lane_dat)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st      <= ST_IDLE;
         cnt     <= '0;
         fbsy    <= 1'b0;
         fdat    <= '0;
         rom_re  <= 1'b0;
         rom_adr <= '0;
         cur_vld <= 1'b0;
         cur_adr <= '0;
         cur_dat <= '0;
         p_cmd   <= CMD_IDLE;
         p_off   <= '0;
         p_adr   <= '0;
`ifdef MCOC_BOOT_PF_EN
         nxt_vld <= 1'b0;
         nxt_adr <= '0;
         nxt_dat <= '0;
`endif
      end else begin
         rom_re <= 1'b0;
         unique case (st)
            ST_IDLE: begin
               if (acc && hit_cur) begin
                  fdat <= lane_dat;
`ifdef MCOC_BOOT_PF_EN
               end else if (acc && hit_nxt) begin
                  fdat    <= lane_dat;
                  cur_adr <= nxt_adr;
                  cur_dat <= nxt_dat;
                  st      <= ST_PF;
                  rom_re  <= 1'b1;
                  rom_adr <= nxt_adr + wadr_t'(1);
                  nxt_adr <= nxt_adr + wadr_t'(1);
                  nxt_vld <= 1'b0;
                  cnt     <= 3'(RLAT);
`endif
               end else if (acc) begin
                  p_cmd   <= bus.fcmd;
                  p_off   <= r_off;
                  p_adr   <= r_adr;
                  fbsy    <= 1'b1;
                  st      <= ST_FETCH;
                  rom_re  <= 1'b1;
                  rom_adr <= r_adr;
               end
            end
            ST_FETCH: begin
               st  <= ST_WAIT;
               cnt <= 3'(RLAT - 1);
            end
            ST_WAIT: begin
               if (cnt == 3'd0) begin
                  fdat    <= lane_dat;
                  fbsy    <= 1'b0;
                  cur_vld <= 1'b1;
                  cur_adr <= p_adr;
                  cur_dat <= bus.rom_dat;
`ifdef MCOC_BOOT_PF_EN
                  st      <= ST_PF;
                  rom_re  <= 1'b1;
                  rom_adr <= p_adr + wadr_t'(1);
                  nxt_adr <= p_adr + wadr_t'(1);
                  nxt_vld <= 1'b0;
                  cnt     <= 3'(RLAT);
`else
                  st      <= ST_IDLE;
`endif
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
`ifdef MCOC_BOOT_PF_EN
            ST_PF: begin
               if (acc && hit_cur) begin
                  fdat <= lane_dat;
               end else if (acc) begin
                  p_cmd <= bus.fcmd;
                  p_off <= r_off;
                  p_adr <= r_adr;
                  fbsy  <= 1'b1;
               end
               if (cnt != 3'd0) begin
                  cnt <= cnt - 3'd1;
               end else if (pf_req && (pf_adr == nxt_adr)) begin
                  fdat    <= lane_dat;
                  fbsy    <= 1'b0;
                  cur_vld <= 1'b1;
                  cur_adr <= nxt_adr;
                  cur_dat <= bus.rom_dat;
                  rom_re  <= 1'b1;
                  rom_adr <= nxt_adr + wadr_t'(1);
                  nxt_adr <= nxt_adr + wadr_t'(1);
                  cnt     <= 3'(RLAT);
               end else begin
                  nxt_dat <= bus.rom_dat;
                  nxt_vld <= 1'b1;
                  if (pf_req) begin
                     st      <= ST_FETCH;
                     rom_re  <= 1'b1;
                     rom_adr <= pf_adr;
                     fbsy    <= 1'b1;
                  end else begin
                     st <= ST_IDLE;
                  end
               end
            end
`endif
            default: st <= ST_IDLE;
         endcase
      end
   end

   assign bus.fbsy    = fbsy;
   assign bus.fdat    = fdat;
   assign bus.rom_re  = rom_re;
   assign bus.rom_adr = rom_adr;

endmodule

// File: tb/tb_mcoc_boot_pf.sv
// Directed bench for mcoc_boot_pf (ROM_AW=7, RLAT=2).
// Prefetch sequences run only when MCOC_BOOT_PF_EN is defined.
module tb_mcoc_boot_pf;
   import mcoc_boot_pkg::*;

   localparam int AW = 7;
   localparam int RL = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mcoc_boot_pf_if #(.ROM_AW(AW)) b ();

   mcoc_boot_pf #(.ROM_AW(AW), .RLAT(RL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b)
   );

   logic [31:0] rom [0:(1<<AW)-1];
   logic [31:0] pipe [RL];

   // ROM macro: data appears RL cycles after the strobe, junk otherwise
   always @(posedge clk) begin
      pipe[0] <= b.rom_re ? rom[b.rom_adr] : 32'hdead_beef;
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
   end
   assign b.rom_dat = pipe[RL-1];

   int nerr = 0;
   int nchk = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] c, input logic [15:0] a);
      b.fcmd = c;
      b.fadr = a;
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_fdat"}, b.fdat, 32'h0);
      chk({tag, "_fbsy"}, 32'(b.fbsy), 32'h0);
      chk({tag, "_re"}, 32'(b.rom_re), 32'h0);
      chk({tag, "_adr"}, 32'(b.rom_adr), 32'h0);
   endtask

   typedef struct {
      logic [1:0]  cmd;
      logic [15:0] adr;
      logic [31:0] dat;
   } vec_t;

   vec_t tv [10];

   initial begin
      tv[0] = '{CMD_HALF, 16'h0012, 32'h0000_3344};
      tv[1] = '{CMD_BYTE, 16'h0011, 32'h0000_0022};
      tv[2] = '{CMD_WORD, 16'h0010, 32'h1122_3344};
      tv[3] = '{CMD_HALF, 16'h0010, 32'h0000_1122};
      tv[4] = '{CMD_BYTE, 16'h0010, 32'h0000_0011};
      tv[5] = '{CMD_BYTE, 16'h0012, 32'h0000_0033};
      tv[6] = '{CMD_BYTE, 16'h0013, 32'h0000_0044};
      tv[7] = '{CMD_HALF, 16'h0011, 32'h0000_1122};
      tv[8] = '{CMD_WORD, 16'h0210, 32'h1122_3344};
      tv[9] = '{CMD_BYTE, 16'h8013, 32'h0000_0044};

      for (int i = 0; i < (1 << AW); i++) rom[i] = {16'he000, 16'(i)};
      rom[4]   = 32'h1122_3344;
      rom[5]   = 32'h5566_7788;
      rom[6]   = 32'h99aa_bbcc;
      rom[12]  = 32'h99aa_bbcc;
      rom[40]  = 32'h0bad_c0de;
      rom[127] = 32'hcafe_f00d;

      rst_n = 1'b0;
      drive(CMD_IDLE, 16'h0);
      tick;
      tick;
      chk_rst("rst");
      rst_n = 1'b1;
      tick;

      // cold miss on word 4
      drive(CMD_WORD, 16'h0010);
      tick;
      drive(CMD_IDLE, 16'h0);
      chk("miss_re", 32'(b.rom_re), 32'h1);
      chk("miss_adr", 32'(b.rom_adr), 32'h4);
      chk("miss_bsy1", 32'(b.fbsy), 32'h1);
      tick;
      chk("miss_bsy2", 32'(b.fbsy), 32'h1);
      chk("miss_re_pulse", 32'(b.rom_re), 32'h0);
      tick;
      chk("miss_bsy3", 32'(b.fbsy), 32'h1);
      tick;
      chk("miss_bsy4", 32'(b.fbsy), 32'h0);
      chk("miss_fdat", b.fdat, 32'h1122_3344);
`ifdef MCOC_BOOT_PF_EN
      chk("pf_re", 32'(b.rom_re), 32'h1);
      chk("pf_adr", 32'(b.rom_adr), 32'h5);
`else
      chk("miss_re_done", 32'(b.rom_re), 32'h0);
`endif

      // back-to-back hits on the filled word
      for (int i = 0; i < 10; i++) begin
         drive(tv[i].cmd, tv[i].adr);
         tick;
         chk($sformatf("hit%0d_fdat", i), b.fdat, tv[i].dat);
         chk($sformatf("hit%0d_fbsy", i), 32'(b.fbsy), 32'h0);
         chk($sformatf("hit%0d_re", i), 32'(b.rom_re), 32'h0);
      end
      drive(CMD_IDLE, 16'h0);

`ifdef MCOC_BOOT_PF_EN
      tick;
      drive(CMD_WORD, 16'h0014);
      tick;
      drive(CMD_IDLE, 16'h0);
      chk("seq_fdat", b.fdat, 32'h5566_7788);
      chk("seq_fbsy", 32'(b.fbsy), 32'h0);
      chk("seq_re", 32'(b.rom_re), 32'h1);
      chk("seq_adr", 32'(b.rom_adr), 32'h6);
`endif
      repeat (4) tick;

      // inputs toggled while busy must not disturb the captured request
      drive(CMD_BYTE, 16'h0031);
      tick;
      chk("busy_bsy1", 32'(b.fbsy), 32'h1);
      drive(CMD_WORD, 16'h0010);
      tick;
      chk("busy_bsy2", 32'(b.fbsy), 32'h1);
      drive(CMD_HALF, 16'h0016);
      tick;
      drive(CMD_BYTE, 16'h0013);
      tick;
      drive(CMD_IDLE, 16'h0);
      chk("busy_done", 32'(b.fbsy), 32'h0);
      chk("busy_fdat", b.fdat, 32'h0000_00aa);
      tick;
      chk("hold_fdat", b.fdat, 32'h0000_00aa);
      chk("hold_fbsy", 32'(b.fbsy), 32'h0);
      repeat (4) tick;

`ifdef MCOC_BOOT_PF_EN
      // wrap of the prefetch address, then a miss raised during prefetch
      drive(CMD_WORD, 16'h01fc);
      tick;
      drive(CMD_IDLE, 16'h0);
      repeat (3) tick;
      chk("wrap_fdat", b.fdat, 32'hcafe_f00d);
      chk("wrap_re", 32'(b.rom_re), 32'h1);
      chk("wrap_adr", 32'(b.rom_adr), 32'h0);
      drive(CMD_WORD, 16'h00a0);
      for (int i = 5; i <= 9; i++) begin
         tick;
         drive(CMD_IDLE, 16'h0);
         chk($sformatf("cfl_bsy_t%0d", i), 32'(b.fbsy), 32'h1);
         if (i == 7) begin
            chk("cfl_re", 32'(b.rom_re), 32'h1);
            chk("cfl_adr", 32'(b.rom_adr), 32'd40);
         end
      end
      tick;
      chk("cfl_fbsy", 32'(b.fbsy), 32'h0);
      chk("cfl_fdat", b.fdat, 32'h0bad_c0de);
      chk("cfl_pf_adr", 32'(b.rom_adr), 32'd41);
      // request for the word still in flight
      drive(CMD_BYTE, 16'h00a7);
      tick;
      drive(CMD_IDLE, 16'h0);
      chk("nxf_bsy1", 32'(b.fbsy), 32'h1);
      tick;
      chk("nxf_bsy2", 32'(b.fbsy), 32'h1);
      tick;
      chk("nxf_fbsy", 32'(b.fbsy), 32'h0);
      chk("nxf_fdat", b.fdat, 32'h0000_0029);
      chk("nxf_re", 32'(b.rom_re), 32'h1);
      chk("nxf_adr", 32'(b.rom_adr), 32'd42);
      repeat (4) tick;
`endif

      // reset in the middle of a miss
      drive(CMD_WORD, 16'h0020);
      tick;
      drive(CMD_IDLE, 16'h0);
      rst_n = 1'b0;
      tick;
      tick;
      chk_rst("midrst");
      rst_n = 1'b1;
      tick;
      drive(CMD_WORD, 16'h0020);
      tick;
      drive(CMD_IDLE, 16'h0);
      chk("rerd_bsy", 32'(b.fbsy), 32'h1);
      chk("rerd_re", 32'(b.rom_re), 32'h1);
      repeat (3) tick;
      chk("rerd_fbsy", 32'(b.fbsy), 32'h0);
      chk("rerd_fdat", b.fdat, 32'he000_0008);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
